// File: rtl/icap_cfg_sequencer.sv
// icap_cfg_sequencer: turns single register read/write requests into complete
// ICAP packet streams (dummy, sync, type-1 header, data, DESYNC tail), with
// read-mode turnaround, multi-word readback and a BUSY timeout.
module icap_cfg_sequencer #(
    parameter int DATA_W         = 16,
    parameter int BIT_REVERSE    = 1,
    parameter int CMD_ADDR       = 5,
    parameter int CNT_W          = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [5:0]        req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [CNT_W-1:0]  req_count,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic              icap_ce_n,
    output logic              icap_write_n,
    output logic [DATA_W-1:0] icap_i,
    input  logic [DATA_W-1:0] icap_o,
    input  logic              icap_busy
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [4:0] S_IDLE      = 5'd0;
    localparam logic [4:0] S_DUMMY     = 5'd1;
    localparam logic [4:0] S_SYNC      = 5'd2;
    localparam logic [4:0] S_NOOP_PRE  = 5'd3;
    localparam logic [4:0] S_HDR       = 5'd4;
    localparam logic [4:0] S_WDATA     = 5'd5;
    localparam logic [4:0] S_RD_NOOP   = 5'd6;
    localparam logic [4:0] S_RD_TURN_A = 5'd7;
    localparam logic [4:0] S_RD_TURN_B = 5'd8;
    localparam logic [4:0] S_RD_DATA   = 5'd9;
    localparam logic [4:0] S_RD_END_A  = 5'd10;
    localparam logic [4:0] S_RD_END_B  = 5'd11;
    localparam logic [4:0] S_NOOP_POST = 5'd12;
    localparam logic [4:0] S_DHDR      = 5'd13;
    localparam logic [4:0] S_DDATA     = 5'd14;
    localparam logic [4:0] S_NOOP_TAIL = 5'd15;
    localparam logic [4:0] S_FINISH    = 5'd16;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    localparam logic [DATA_W-1:0] DUMMY_WORD  = '1;
    localparam logic [DATA_W-1:0] NOOP_WORD   = (DATA_W == 32) ? DATA_W'(32'h2000_0000) : DATA_W'(16'h2000);
    localparam logic [DATA_W-1:0] SYNC_W0     = (DATA_W == 32) ? DATA_W'(32'hAA99_5566) : DATA_W'(16'hAA99);
    localparam logic [DATA_W-1:0] SYNC_W1     = DATA_W'(16'h5566);
    localparam logic [DATA_W-1:0] DESYNC_WORD = DATA_W'(16'h000D);

    // Type-1 packet header in the layout of the configured port width.
    function automatic logic [DATA_W-1:0] type1_hdr(input logic [1:0] op, input logic [5:0] addr,
                                                    input logic [10:0] cnt);
        logic [15:0] h16;
        logic [31:0] h32;
        h16 = {3'b001, op, addr, cnt[4:0]};
        h32 = {3'b001, op, 9'b0, addr[4:0], 2'b00, cnt};
        if (DATA_W == 32) return DATA_W'(h32);
        return DATA_W'(h16);
    endfunction

    // Per-byte bit reversal; it is its own inverse, so it serves both directions.
    function automatic logic [DATA_W-1:0] bit_order(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = w;
        if (BIT_REVERSE != 0) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                for (int i = 0; i < 8; i++) begin
                    r[b*8 + i] = w[b*8 + 7 - i];
                end
            end
        end
        return r;
    endfunction

    logic [4:0]        state_q, state_nxt;
    logic              idx_q, idx_nxt;
    logic              op_q;
    logic [5:0]        addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_eff;
    logic [CNT_W-1:0]  rcnt_q;
    logic [TO_W-1:0]   tcnt_q;
    logic              err_sticky_q;
    logic              accept, rd_take, rd_final, rd_abort;
    logic [DATA_W-1:0] word_nxt;
    logic              ce_n_nxt, write_n_nxt;

    assign accept   = req_valid && ((state_q == S_IDLE) || (state_q == S_FINISH));
    assign cnt_eff  = (cnt_q == '0) ? CNT_W'(1) : cnt_q;
    assign rd_take  = (state_q == S_RD_DATA) && !icap_busy;
    assign rd_final = rd_take && (rcnt_q == cnt_eff - CNT_W'(1));
    assign rd_abort = (state_q == S_RD_DATA) && icap_busy && (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Sequence walker; idx selects the second word of two-word states.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = 1'b0;
        case (state_q)
            S_IDLE:      if (req_valid) state_nxt = S_DUMMY;
            S_FINISH:    state_nxt = req_valid ? S_DUMMY : S_IDLE;
            S_DUMMY:     state_nxt = S_SYNC;
            S_SYNC: begin
                if (DATA_W == 16 && !idx_q) idx_nxt = 1'b1;
                else                        state_nxt = S_NOOP_PRE;
            end
            S_NOOP_PRE:  state_nxt = S_HDR;
            S_HDR:       state_nxt = op_q ? S_RD_NOOP : S_WDATA;
            S_WDATA:     state_nxt = S_NOOP_POST;
            S_RD_NOOP: begin
                if (!idx_q) idx_nxt = 1'b1;
                else        state_nxt = S_RD_TURN_A;
            end
            S_RD_TURN_A: state_nxt = S_RD_TURN_B;
            S_RD_TURN_B: state_nxt = S_RD_DATA;
            S_RD_DATA:   if (rd_final || rd_abort) state_nxt = S_RD_END_A;
            S_RD_END_A:  state_nxt = S_RD_END_B;
            S_RD_END_B:  state_nxt = S_NOOP_POST;
            S_NOOP_POST: state_nxt = S_DHDR;
            S_DHDR:      state_nxt = S_DDATA;
            S_DDATA:     state_nxt = S_NOOP_TAIL;
            S_NOOP_TAIL: begin
                if (!idx_q) idx_nxt = 1'b1;
                else        state_nxt = S_FINISH;
            end
            default:     state_nxt = S_IDLE;
        endcase
    end

    // ICAP word and strobes for the state about to be entered, so the port is registered.
    always_comb begin
        word_nxt    = DUMMY_WORD;
        ce_n_nxt    = 1'b0;
        write_n_nxt = 1'b0;
        case (state_nxt)
            S_DUMMY:     word_nxt = DUMMY_WORD;
            S_SYNC:      word_nxt = idx_nxt ? SYNC_W1 : SYNC_W0;
            S_NOOP_PRE, S_RD_NOOP, S_NOOP_POST, S_NOOP_TAIL:
                         word_nxt = NOOP_WORD;
            S_HDR:       word_nxt = op_q ? type1_hdr(OP_READ, addr_q, 11'(cnt_eff))
                                         : type1_hdr(OP_WRITE, addr_q, 11'd1);
            S_WDATA:     word_nxt = data_q;
            S_DHDR:      word_nxt = type1_hdr(OP_WRITE, 6'(CMD_ADDR), 11'd1);
            S_DDATA:     word_nxt = DESYNC_WORD;
            S_RD_TURN_A: ce_n_nxt = 1'b1;
            S_RD_TURN_B: begin ce_n_nxt = 1'b1; write_n_nxt = 1'b1; end
            S_RD_DATA:   write_n_nxt = 1'b1;
            S_RD_END_A:  begin ce_n_nxt = 1'b1; write_n_nxt = 1'b1; end
            S_RD_END_B:  ce_n_nxt = 1'b1;
            default:     ce_n_nxt = 1'b1;
        endcase
    end

    // Request fields are frozen at acceptance for the whole sequence.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            data_q <= req_data;
            cnt_q  <= req_count;
        end
    end

    // Control state, ICAP port registers, readback capture and status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 1'b0;
            rcnt_q       <= '0;
            tcnt_q       <= '0;
            err_sticky_q <= 1'b0;
            req_ready    <= 1'b1;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_data      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            icap_ce_n    <= 1'b1;
            icap_write_n <= 1'b0;
            icap_i       <= '1;
        end else begin
            state_q      <= state_nxt;
            idx_q        <= idx_nxt;
            req_ready    <= (state_nxt == S_IDLE) || (state_nxt == S_FINISH);
            done         <= (state_nxt == S_FINISH);
            err          <= (state_nxt == S_FINISH) && err_sticky_q;
            icap_ce_n    <= ce_n_nxt;
            icap_write_n <= write_n_nxt;
            icap_i       <= bit_order(word_nxt);
            rd_valid     <= rd_take;
            rd_last      <= rd_final;
            if (rd_take) rd_data <= bit_order(icap_o);

            if (state_q == S_RD_TURN_B) rcnt_q <= '0;
            else if (rd_take)           rcnt_q <= rcnt_q + CNT_W'(1);

            if (state_q != S_RD_DATA || rd_take) tcnt_q <= '0;
            else                                 tcnt_q <= tcnt_q + TO_W'(1);

            if (state_nxt == S_DUMMY) err_sticky_q <= 1'b0;
            else if (rd_abort)        err_sticky_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icap_cfg_sequencer.sv
// Directed bench for icap_cfg_sequencer: 16-bit plain and bit-reversed
// instances share one stimulus; a 32-bit instance covers reads and timeout.
module tb_icap_cfg_sequencer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;
    int checks = 0;
    int errors = 0;

    // 16-bit shared stimulus
    logic        a_valid, a_op, a_busy;
    logic [5:0]  a_addr;
    logic [15:0] a_data, a_icap_o;
    logic [4:0]  a_count;
    // 16-bit plain outputs
    logic        n_ready, n_rdv, n_rdl, n_done, n_err, n_ce, n_wn;
    logic [15:0] n_rdd, n_icap;
    // 16-bit reversed outputs
    logic        r_ready, r_rdv, r_rdl, r_done, r_err, r_ce, r_wn;
    logic [15:0] r_rdd, r_icap;
    // 32-bit stimulus and outputs
    logic        b_valid, b_op, b_busy;
    logic [5:0]  b_addr;
    logic [31:0] b_data, b_icap_o;
    logic [4:0]  b_count;
    logic        w_ready, w_rdv, w_rdl, w_done, w_err, w_ce, w_wn;
    logic [31:0] w_rdd, w_icap;

    logic [15:0] exp16  [11] = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000, 16'h3201, 16'h0000,
                                 16'h2000, 16'h30A1, 16'h000D, 16'h2000, 16'h2000};
    logic [15:0] exp16r [11] = '{16'hFFFF, 16'h5599, 16'hAA66, 16'h0400, 16'h4C80, 16'h0000,
                                 16'h0400, 16'h0C85, 16'h00B0, 16'h0400, 16'h0400};
    logic [31:0] exp32  [10] = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001, 32'h0,
                                 32'h20000000, 32'h30008001, 32'h0000000D, 32'h20000000, 32'h20000000};

    icap_cfg_sequencer #(.DATA_W(16), .BIT_REVERSE(0), .CMD_ADDR(5), .CNT_W(5), .TIMEOUT_CYCLES(1024)) u16 (
        .clock(clock), .reset(reset), .req_valid(a_valid), .req_ready(n_ready), .req_op(a_op),
        .req_addr(a_addr), .req_data(a_data), .req_count(a_count), .rd_valid(n_rdv), .rd_data(n_rdd),
        .rd_last(n_rdl), .done(n_done), .err(n_err), .icap_ce_n(n_ce), .icap_write_n(n_wn),
        .icap_i(n_icap), .icap_o(a_icap_o), .icap_busy(a_busy));

    icap_cfg_sequencer #(.DATA_W(16), .BIT_REVERSE(1), .CMD_ADDR(5), .CNT_W(5), .TIMEOUT_CYCLES(1024)) u16r (
        .clock(clock), .reset(reset), .req_valid(a_valid), .req_ready(r_ready), .req_op(a_op),
        .req_addr(a_addr), .req_data(a_data), .req_count(a_count), .rd_valid(r_rdv), .rd_data(r_rdd),
        .rd_last(r_rdl), .done(r_done), .err(r_err), .icap_ce_n(r_ce), .icap_write_n(r_wn),
        .icap_i(r_icap), .icap_o(a_icap_o), .icap_busy(a_busy));

    icap_cfg_sequencer #(.DATA_W(32), .BIT_REVERSE(0), .CMD_ADDR(4), .CNT_W(5), .TIMEOUT_CYCLES(8)) u32 (
        .clock(clock), .reset(reset), .req_valid(b_valid), .req_ready(w_ready), .req_op(b_op),
        .req_addr(b_addr), .req_data(b_data), .req_count(b_count), .rd_valid(w_rdv), .rd_data(w_rdd),
        .rd_last(w_rdl), .done(w_done), .err(w_err), .icap_ce_n(w_ce), .icap_write_n(w_wn),
        .icap_i(w_icap), .icap_o(b_icap_o), .icap_busy(b_busy));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expects a 16-bit write already presented on a_*; follows it to done.
    task automatic write16_check(input logic [15:0] d, input logic [15:0] drev);
        logic [15:0] e, er;
        step();
        a_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            e  = (k == 5) ? d : exp16[k];
            er = (k == 5) ? drev : exp16r[k];
            chk($sformatf("w16 icap_i[%0d]", k), 32'(n_icap), 32'(e));
            chk($sformatf("w16 ce_n[%0d]", k), 32'(n_ce), 32'(1'b0));
            chk($sformatf("w16r icap_i[%0d]", k), 32'(r_icap), 32'(er));
            chk($sformatf("w16 done early[%0d]", k), 32'(n_done), 32'(1'b0));
            step();
        end
        chk("w16 done", 32'(n_done), 32'(1'b1));
        chk("w16 ready at done", 32'(n_ready), 32'(1'b1));
        chk("w16 ce_n at done", 32'(n_ce), 32'(1'b1));
        chk("w16 err", 32'(n_err), 32'(1'b0));
        chk("w16r done", 32'(r_done), 32'(1'b1));
        chk("w16 rd_valid", 32'(n_rdv), 32'(1'b0));
        step();
        chk("w16 done cleared", 32'(n_done), 32'(1'b0));
        chk("w16 ready idle", 32'(n_ready), 32'(1'b1));
    endtask

    int busy_cyc, rdv_cnt, done_at, err_at_done, err_cnt, desync_seen, rdl_cnt;

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; a_op = 1'b0; a_busy = 1'b0; a_addr = '0; a_data = '0; a_icap_o = '0; a_count = '0;
        b_valid = 1'b0; b_op = 1'b0; b_busy = 1'b0; b_addr = '0; b_data = '0; b_icap_o = '0; b_count = '0;
        step();
        step();
        // reset values
        chk("rst n ce_n", 32'(n_ce), 32'(1'b1));
        chk("rst n write_n", 32'(n_wn), 32'(1'b0));
        chk("rst n icap_i", 32'(n_icap), 32'h0000FFFF);
        chk("rst n ready", 32'(n_ready), 32'(1'b1));
        chk("rst n rd_valid", 32'(n_rdv), 32'(1'b0));
        chk("rst n rd_last", 32'(n_rdl), 32'(1'b0));
        chk("rst n rd_data", 32'(n_rdd), 32'h0);
        chk("rst n done", 32'(n_done), 32'(1'b0));
        chk("rst n err", 32'(n_err), 32'(1'b0));
        chk("rst r ce_n", 32'(r_ce), 32'(1'b1));
        chk("rst r write_n", 32'(r_wn), 32'(1'b0));
        chk("rst r icap_i", 32'(r_icap), 32'h0000FFFF);
        chk("rst r ready", 32'(r_ready), 32'(1'b1));
        chk("rst r rd_valid", 32'(r_rdv), 32'(1'b0));
        chk("rst r rd_last", 32'(r_rdl), 32'(1'b0));
        chk("rst r rd_data", 32'(r_rdd), 32'h0);
        chk("rst r err", 32'(r_err), 32'(1'b0));
        chk("rst w ce_n", 32'(w_ce), 32'(1'b1));
        chk("rst w write_n", 32'(w_wn), 32'(1'b0));
        chk("rst w icap_i", w_icap, 32'hFFFFFFFF);
        chk("rst w ready", 32'(w_ready), 32'(1'b1));
        chk("rst w rd_valid", 32'(w_rdv), 32'(1'b0));
        chk("rst w rd_last", 32'(w_rdl), 32'(1'b0));
        chk("rst w rd_data", w_rdd, 32'h0);
        chk("rst w done", 32'(w_done), 32'(1'b0));
        chk("rst w err", 32'(w_err), 32'(1'b0));
        reset = 1'b0;
        step();

        // 16-bit write, plain and bit-reversed
        a_valid = 1'b1; a_op = 1'b0; a_addr = 6'h10; a_data = 16'h1234;
        write16_check(16'h1234, 16'h482C);

        // reset during WDATA, then a clean write
        a_valid = 1'b1; a_data = 16'hC3A5;
        step();
        a_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("wdata word", 32'(n_icap), 32'h0000C3A5);
        reset = 1'b1;
        step();
        chk("mid-reset ce_n", 32'(n_ce), 32'(1'b1));
        chk("mid-reset ready", 32'(n_ready), 32'(1'b1));
        chk("mid-reset icap_i", 32'(n_icap), 32'h0000FFFF);
        chk("mid-reset done", 32'(n_done), 32'(1'b0));
        chk("mid-reset r ce_n", 32'(r_ce), 32'(1'b1));
        reset = 1'b0;
        a_valid = 1'b1; a_data = 16'hBEEF;
        write16_check(16'hBEEF, 16'h7DF7);

        // req_valid held high: back-to-back writes separated by the done cycle
        a_valid = 1'b1; a_data = 16'h1234;
        step();
        for (int c = 1; c <= 24; c++) begin
            chk($sformatf("b2b done[%0d]", c), 32'(n_done), 32'(c == 12 || c == 24));
            chk($sformatf("b2b ready[%0d]", c), 32'(n_ready), 32'(c == 12 || c == 24));
            chk($sformatf("b2b ce_n[%0d]", c), 32'(n_ce), 32'(c == 12 || c == 24));
            if (c == 13) chk("b2b dummy", 32'(n_icap), 32'h0000FFFF);
            if (c == 24) a_valid = 1'b0;
            step();
        end
        chk("b2b idle ready", 32'(n_ready), 32'(1'b1));
        chk("b2b idle ce_n", 32'(n_ce), 32'(1'b1));
        chk("b2b idle done", 32'(n_done), 32'(1'b0));

        // 32-bit write
        b_valid = 1'b1; b_op = 1'b0; b_addr = 6'h10; b_data = 32'h12345678;
        step();
        b_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("w32 icap_i[%0d]", k), w_icap, (k == 4) ? 32'h12345678 : exp32[k]);
            chk($sformatf("w32 ce_n[%0d]", k), 32'(w_ce), 32'(1'b0));
            step();
        end
        chk("w32 done", 32'(w_done), 32'(1'b1));
        chk("w32 ready", 32'(w_ready), 32'(1'b1));
        step();
        chk("w32 done cleared", 32'(w_done), 32'(1'b0));

        // 32-bit read, count 3, BUSY high for the first 4 read cycles
        b_valid = 1'b1; b_op = 1'b1; b_addr = 6'h0E; b_count = 5'd3; b_busy = 1'b1;
        step();
        b_valid = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            b_busy   = !(c >= 13 && c <= 15);
            b_icap_o = (c >= 13 && c <= 15) ? 32'(32'hA0 + (c - 13)) : 32'h0;
            chk($sformatf("rd ce_n[%0d]", c), 32'(w_ce), 32'(c == 7 || c == 8 || c == 16 || c == 17 || c == 23));
            chk($sformatf("rd write_n[%0d]", c), 32'(w_wn), 32'(c >= 8 && c <= 16));
            chk($sformatf("rd rd_valid[%0d]", c), 32'(w_rdv), 32'(c >= 14 && c <= 16));
            chk($sformatf("rd rd_last[%0d]", c), 32'(w_rdl), 32'(c == 16));
            chk($sformatf("rd done[%0d]", c), 32'(w_done), 32'(c == 23));
            if (c >= 14 && c <= 16) chk($sformatf("rd rd_data[%0d]", c), w_rdd, 32'(32'hA0 + (c - 14)));
            if (c == 23) chk("rd err", 32'(w_err), 32'(1'b0));
            case (c)
                1:                    chk("rd dummy", w_icap, 32'hFFFFFFFF);
                2:                    chk("rd sync", w_icap, 32'hAA995566);
                4:                    chk("rd header", w_icap, 32'h2801C003);
                3, 5, 6, 18, 21, 22:  chk($sformatf("rd noop[%0d]", c), w_icap, 32'h20000000);
                19:                   chk("rd desync hdr", w_icap, 32'h30008001);
                20:                   chk("rd desync data", w_icap, 32'h0000000D);
                default: ;
            endcase
            step();
        end
        b_busy = 1'b1;
        chk("rd ready after", 32'(w_ready), 32'(1'b1));

        // 32-bit read with BUSY stuck high: timeout after 8 cycles
        b_valid = 1'b1; b_op = 1'b1; b_addr = 6'h0E; b_count = 5'd2;
        step();
        b_valid = 1'b0;
        busy_cyc = 0; rdv_cnt = 0; done_at = 0; err_at_done = 0; err_cnt = 0; desync_seen = 0; rdl_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            if (w_ce == 1'b0 && w_wn == 1'b1) busy_cyc++;
            if (w_rdv) rdv_cnt++;
            if (w_rdl) rdl_cnt++;
            if (w_err) err_cnt++;
            if (w_ce == 1'b0 && w_icap == 32'h30008001) desync_seen = 1;
            if (w_done && done_at == 0) begin
                done_at = c;
                err_at_done = int'(w_err);
            end
            step();
        end
        b_busy = 1'b0;
        chk("to busy cycles", 32'(busy_cyc), 32'd8);
        chk("to rd_valid count", 32'(rdv_cnt), 32'd0);
        chk("to rd_last count", 32'(rdl_cnt), 32'd0);
        chk("to done cycle", 32'(done_at), 32'd24);
        chk("to err with done", 32'(err_at_done), 32'd1);
        chk("to err pulses", 32'(err_cnt), 32'd1);
        chk("to desync issued", 32'(desync_seen), 32'd1);
        chk("to ready after", 32'(w_ready), 32'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
